// File: rtl/pilha_parametrizada_if.sv
// Signal bundle for the parametrised return stack: control strobes and data in,
// registered top-of-stack and status out.
interface pilha_parametrizada_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    // No valid/ready handshake: push/pop/limpa/clr_err are single-cycle strobes
    // sampled on every rising edge; a held strobe repeats its operation each cycle.
    logic             push;
    logic             pop;
    logic             limpa;
    logic             clr_err;
    logic [WIDTH-1:0] dado;
    logic [WIDTH-1:0] saida;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, limpa, clr_err, dado,
        input  saida, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, limpa, clr_err, dado,
        output saida, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/pilha_parametrizada.sv
// Parametrised return stack with registered top-of-stack, occupancy, full/empty,
// sticky overflow/underflow flags, push+pop replace-top and synchronous flush.
module pilha_parametrizada #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    pilha_parametrizada_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_saida;
    logic             r_empty;
    logic             r_full;
    logic             r_overflow;
    logic             r_underflow;

    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_saida_nxt;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic [AW-1:0]    w_push_idx;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_below_idx;

    // Index arithmetic wraps on the low AW bits; count itself never wraps.
    assign w_push_idx  = AW'(r_count);
    assign w_top_idx   = AW'(r_count - CW'(1));
    assign w_below_idx = AW'(r_count - CW'(2));

    always_comb begin
        w_count_nxt = r_count;
        w_saida_nxt = r_saida;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_push_idx;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        if (bus.limpa) begin
            w_count_nxt = '0;
            w_saida_nxt = '0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (r_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = w_push_idx;
                        w_count_nxt = r_count + CW'(1);
                        w_saida_nxt = bus.dado;
                    end
                end
                2'b01: begin
                    if (r_empty) begin
                        w_set_udf = 1'b1;
                    end else if (r_count == CW'(1)) begin
                        w_count_nxt = '0;
                        w_saida_nxt = '0;
                    end else begin
                        w_count_nxt = r_count - CW'(1);
                        w_saida_nxt = r_mem[w_below_idx];
                    end
                end
                2'b11: begin
                    // On an empty stack push+pop degenerates to a plain push.
                    w_wr_en     = 1'b1;
                    w_saida_nxt = bus.dado;
                    if (r_empty) begin
                        w_wr_idx    = '0;
                        w_count_nxt = CW'(1);
                    end else begin
                        w_wr_idx    = w_top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_saida     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_saida     <= w_saida_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == CW'(DEPTH));
            // A set event on the same edge as clr_err leaves the flag set.
            r_overflow  <= w_set_ovf | (r_overflow  & ~bus.clr_err);
            r_underflow <= w_set_udf | (r_underflow & ~bus.clr_err);
        end
    end

    // Storage is deliberately left uncleared by reset and flush.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.dado;
        end
    end

    assign bus.saida     = r_saida;
    assign bus.count     = r_count;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_pilha_parametrizada.sv
// Directed bench for the return stack: a DEPTH=4/WIDTH=8 instance for the main
// sequence and a DEPTH=32/WIDTH=32 instance for reset during a push.
module tb_pilha_parametrizada;
    logic clk;
    logic rst4;
    logic rst32;
    int   total;
    int   bad;

    pilha_parametrizada_if #(.WIDTH(8),  .DEPTH(4))  if4  ();
    pilha_parametrizada_if #(.WIDTH(32), .DEPTH(32)) if32 ();

    pilha_parametrizada #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4.slave)
    );

    pilha_parametrizada #(.WIDTH(32), .DEPTH(32)) u_dut32 (
        .clk (clk),
        .rst (rst32),
        .bus (if32.slave)
    );

    // clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [7:0] saida, input logic [2:0] count,
                          input logic empty, input logic full, input logic ovf, input logic udf);
        check({tag, ".saida"},     64'(if4.saida),     64'(saida));
        check({tag, ".count"},     64'(if4.count),     64'(count));
        check({tag, ".empty"},     64'(if4.empty),     64'(empty));
        check({tag, ".full"},      64'(if4.full),      64'(full));
        check({tag, ".overflow"},  64'(if4.overflow),  64'(ovf));
        check({tag, ".underflow"}, 64'(if4.underflow), 64'(udf));
    endtask

    task automatic check32(input string tag, input logic [31:0] saida, input logic [5:0] count,
                           input logic empty);
        check({tag, ".saida"}, 64'(if32.saida), 64'(saida));
        check({tag, ".count"}, 64'(if32.count), 64'(count));
        check({tag, ".empty"}, 64'(if32.empty), 64'(empty));
        check({tag, ".full"},  64'(if32.full),  64'(1'b0));
    endtask

    // drive one operation, apply one rising edge, sample #1 after it
    task automatic op4(input logic pu, input logic po, input logic li, input logic ce,
                       input logic [7:0] d);
        if4.push = pu; if4.pop = po; if4.limpa = li; if4.clr_err = ce; if4.dado = d;
        @(posedge clk);
        #1;
        if4.push = 1'b0; if4.pop = 1'b0; if4.limpa = 1'b0; if4.clr_err = 1'b0; if4.dado = '0;
    endtask

    task automatic op32(input logic pu, input logic [31:0] d);
        if32.push = pu; if32.dado = d;
        @(posedge clk);
        #1;
        if32.push = 1'b0; if32.dado = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst4  = 1'b0;
        rst32 = 1'b0;
        if4.push = 1'b0;  if4.pop = 1'b0;  if4.limpa = 1'b0;  if4.clr_err = 1'b0;  if4.dado = '0;
        if32.push = 1'b0; if32.pop = 1'b0; if32.limpa = 1'b0; if32.clr_err = 1'b0; if32.dado = '0;

        // reset and idle
        repeat (2) @(negedge clk);
        check4("rst_hold", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst4  = 1'b1;
        rst32 = 1'b1;
        op4(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check4("idle", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-cycle, no clock edge in between
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'hAB);
        check4("pre_rst", 8'hAB, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst4 = 1'b0;
        #1 check4("async_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst4 = 1'b1;

        // fill
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h11); check4("fill1", 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h22); check4("fill2", 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h33); check4("fill3", 8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h44); check4("fill4", 8'h44, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);

        // overflow, then overflow racing clr_err
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h55); check4("ovf",      8'h44, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        op4(1'b1, 1'b0, 1'b0, 1'b1, 8'h66); check4("ovf_race", 8'h44, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);

        // drain, overflow stays sticky
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("drain1", 8'h33, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("drain2", 8'h22, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("drain3", 8'h11, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("drain4", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        op4(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check4("clr_ovf", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // underflow, race with clr_err, then clear
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("udf",      8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        op4(1'b0, 1'b1, 1'b0, 1'b1, 8'h00); check4("udf_race", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        op4(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); check4("clr_udf",  8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // replace top
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h22); check4("rep_pre",  8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b1, 1'b0, 1'b0, 8'h99); check4("replace",  8'h99, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("rep_pop",  8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("rep_pop2", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b1, 1'b0, 1'b0, 8'h07); check4("pp_empty", 8'h07, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // replace top while full: legal, no overflow; entry below is intact
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'hA3); check4("full_pre",  8'hA3, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        op4(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE); check4("full_rep",  8'hEE, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        op4(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); check4("full_pop",  8'hA2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // flush beats push; stack usable straight afterwards
        op4(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A); check4("flush",      8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        op4(1'b1, 1'b0, 1'b0, 1'b0, 8'h12); check4("post_flush", 8'h12, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // DEPTH=32: reset asserted during a push loses the push
        op32(1'b1, 32'hDEADBEEF);
        op32(1'b1, 32'h00000001);
        check32("d32_pre", 32'h00000001, 6'd2, 1'b0);
        if32.push = 1'b1;
        if32.dado = 32'h00000055;
        #2 rst32 = 1'b0;
        #1 check32("d32_async", 32'h0, 6'd0, 1'b1);
        @(posedge clk);
        #1 check32("d32_held", 32'h0, 6'd0, 1'b1);
        @(negedge clk);
        rst32     = 1'b1;
        if32.push = 1'b0;
        if32.dado = '0;
        @(posedge clk);
        #1 check32("d32_lost", 32'h0, 6'd0, 1'b1);
        op32(1'b1, 32'h00000077);
        check32("d32_push", 32'h00000077, 6'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
